// File: rtl/alu_pkg.sv
// Shared opcode encodings, handshake state type and op-class helper
// for the sequential ALU with iterative multiply/divide.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SRA   = 4'b1010;
  localparam logic [OP_W-1:0] OP_MULTU = 4'b1100;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// {hi, lo} is the shared accumulator: product or {remainder, quotient}.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // Next accumulator value for a single iteration.
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    trial = {hi, lo[WIDTH-1]};
    qbit  = (trial >= {1'b0, opb});
    lo_c  = '0;
    hi_c  = '0;
    if (div_q) begin
      // Remainder after subtraction is always below the divisor, so WIDTH bits suffice.
      hi_c = qbit ? (trial[WIDTH-1:0] - opb) : trial[WIDTH-1:0];
      lo_c = {lo[WIDTH-2:0], qbit};
    end else begin
      hi_c = sum[WIDTH:1];
      lo_c = {sum[0], lo[WIDTH-1:1]};
    end
  end

  assign last_c = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      opb   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      cnt   <= CNT_W'(WIDTH);
      div_q <= mode_div;
      opb   <= b;
      hi    <= '0;
      lo    <= a;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      hi  <= hi_c;
      lo  <= lo_c;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus
// iterative MULTU/DIVU, with an IDLE/BUSY/DONE valid-ready wrapper.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_zero,
  output logic             out_ovf
);

  state_t state, state_nxt;
  logic   start, load_single, load_iter;

  logic [WIDTH-1:0] alu_lo, sum, diff;
  logic [SH_W-1:0]  sh;
  logic             alu_ovf, alu_zero_en;

  logic             it_last;
  logic [WIDTH-1:0] it_lo, it_hi;

  // Single-cycle datapath; unknown opcodes give zero result with flags cleared.
  always_comb begin
    alu_lo      = '0;
    alu_ovf     = 1'b0;
    alu_zero_en = 1'b1;
    sum         = in_a + in_b;
    diff        = in_a - in_b;
    sh          = in_b[SH_W-1:0];
    case (in_op)
      OP_AND:  alu_lo = in_a & in_b;
      OP_OR:   alu_lo = in_a | in_b;
      OP_XOR:  alu_lo = in_a ^ in_b;
      OP_NOR:  alu_lo = ~(in_a | in_b);
      OP_ADD: begin
        alu_lo  = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo  = diff;
        alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLTU: alu_lo = WIDTH'(in_a < in_b);
      OP_SLT:  alu_lo = WIDTH'($signed(in_a) < $signed(in_b));
      OP_SLL:  alu_lo = in_a << sh;
      OP_SRL:  alu_lo = in_a >> sh;
      OP_SRA:  alu_lo = WIDTH'($signed(in_a) >>> sh);
      default: alu_zero_en = 1'b0;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode_div (in_op == OP_DIVU),
    .a        (in_a),
    .b        (in_b),
    .last_c   (it_last),
    .lo_c     (it_lo),
    .hi_c     (it_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    load_single = 1'b0;
    load_iter   = 1'b0;
    case (state)
      S_IDLE: if (in_valid) begin
        if (is_multicycle(in_op)) begin
          start     = 1'b1;
          state_nxt = S_BUSY;
        end else begin
          load_single = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_BUSY: if (it_last) begin
        load_iter = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result and flags registered together so they stay aligned with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_lo   <= '0;
      out_hi   <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (load_single) begin
      out_lo   <= alu_lo;
      out_hi   <= '0;
      out_zero <= alu_zero_en && (alu_lo == '0);
      out_ovf  <= alu_ovf;
    end else if (load_iter) begin
      out_lo   <= it_lo;
      out_hi   <= it_hi;
      out_zero <= (it_lo == '0);
      out_ovf  <= 1'b0;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq (WIDTH=32).
module tb_alu_muldiv_seq;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lo, out_hi;
  logic             out_zero, out_ovf;

  int errors = 0;
  int checks = 0;

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lo    (out_lo),
    .out_hi    (out_hi),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one op at #1 after an edge; returns #1 after the accept edge with operands scrambled.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Edges counted from the accept edge until out_valid is seen; tracks in_ready meanwhile.
  task automatic wait_valid(output int lat, output logic rdy_low);
    lat     = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_lo,
                            input logic exp_zero, input logic exp_ovf);
    int   lat;
    logic rl;
    issue(tag, op, a, b);
    wait_valid(lat, rl);
    chk({tag, ".latency"}, 64'(lat), 64'd0);
    chk({tag, ".lo"}, 64'(out_lo), 64'(exp_lo));
    chk({tag, ".hi"}, 64'(out_hi), 64'd0);
    chk({tag, ".zero"}, 64'(out_zero), 64'(exp_zero));
    chk({tag, ".ovf"}, 64'(out_ovf), 64'(exp_ovf));
    release_result(tag);
  endtask

  // Multi-cycle: out_valid in cycle N+WIDTH+1, i.e. WIDTH edges after accept edge N.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
    int   lat;
    logic rl;
    issue(tag, op, a, b);
    wait_valid(lat, rl);
    chk({tag, ".latency"}, 64'(lat), 64'd32);
    chk({tag, ".ready_low"}, 64'(rl), 64'd1);
    chk({tag, ".lo"}, 64'(out_lo), 64'(exp_lo));
    chk({tag, ".hi"}, 64'(out_hi), 64'(exp_hi));
    chk({tag, ".zero"}, 64'(out_zero), 64'(exp_lo == 32'd0));
    chk({tag, ".ovf"}, 64'(out_ovf), 64'd0);
    release_result(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.lo", 64'(out_lo), 64'd0);
    chk("rst.hi", 64'(out_hi), 64'd0);
    chk("rst.zero", 64'(out_zero), 64'd0);
    chk("rst.ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;
    chk("rst.ready", 64'(in_ready), 64'd1);

    run_single("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    run_single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    run_single("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_single("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_single("sltu", 4'b0101, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_single("sra", 4'b1010, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
    run_single("srl", 4'b1001, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0);
    run_single("sll", 4'b1000, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0);
    run_single("and", 4'b0000, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1'b0, 1'b0);
    run_single("or", 4'b0001, 32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF, 1'b0, 1'b0);
    run_single("nor", 4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0);
    run_single("illegal", 4'b1111, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0);

    run_multi("multu", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    run_multi("multu_small", 4'b1100, 32'd12345, 32'd1000, 32'd12345000, 32'd0);
    run_multi("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 32'd2);
    run_multi("divu_zero", 4'b1101, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);

    // Backpressure: result must hold and new requests must be ignored.
    issue("bp", 4'b0011, 32'hF0F0F0F0, 32'hFFFF0000);
    in_valid = 1'b1;
    in_op    = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.ready", 64'(in_ready), 64'd0);
      chk("bp.lo", 64'(out_lo), 64'h0F0FF0F0);
      chk("bp.hi", 64'(out_hi), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_result("bp");
    run_single("bp_next", 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a divide.
    issue("rst_div", 4'b1101, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_div.busy", 64'(out_valid), 64'd0);
    chk("rst_div.busy_lo", 64'(out_lo), 64'd42);
    rst = 1'b1;
    #1;
    chk("rst_div.valid", 64'(out_valid), 64'd0);
    chk("rst_div.lo", 64'(out_lo), 64'd0);
    chk("rst_div.hi", 64'(out_hi), 64'd0);
    chk("rst_div.zero", 64'(out_zero), 64'd0);
    chk("rst_div.ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_div.ready", 64'(in_ready), 64'd1);
    run_single("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
